// File: rtl/ftdi_fifo_bridge.sv
// ftdi_fifo_bridge
//   Async-245 FIFO bridge between fabric logic and an FT232H/FT2232H ADBUS.
//   It contains a show-ahead RX queue (FTDI -> fabric) and a TX queue
//   (fabric -> FTDI). One small FSM times the RD#/WR# strobes in clock cycles
//   and arbitrates between reads and writes.
//
// Optional build macro:
//   FTDI_SYNC_EN  when defined, txe/rxf go through 2-flop synchronizers that
//                 reset to 1 (inactive). This adds 2 cycles of detection latency.
//
// Ports:
//   clock, reset          system clock; asynchronous active-high reset
//   clear                 synchronous flush of both queues and the FSM
//   txe, rxf              FTDI TXE#/RXF#, both active-low
//   wr_en, rd_en          allow FTDI write/read transactions
//   wrreq, data_wr        push a byte into the TX queue
//   rdreq, data_rd        pop the RX queue; data_rd is the current head
//   adbus_in/out, adbus_tri  pad data in/out; tri=1 means the FPGA drives ADBUS
//   ftdi_wr, ftdi_rd      WR#/RD# strobes, both active-low
//   rdq_*/wrq_*           queue flags and occupancy (0..DEPTH)
//   busy                  FSM is outside IDLE

module ftdi_fifo_bridge_queue #(
  parameter int DEPTH = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     used
);
  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // A push into a full queue is dropped even when a pop happens in the same
  // cycle; a pop from an empty queue is also dropped.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (used == UW'(DEPTH));
  assign empty   = (used == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      used <= used + UW'(push_ok) - UW'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !clear) mem[wr_ptr] <= din;
  end
endmodule

module ftdi_fifo_bridge #(
  parameter int DEPTH          = 1024,
  parameter int WR_SETUP_CYC   = 1,
  parameter int WR_PULSE_CYC   = 2,
  parameter int RD_PULSE_CYC   = 2,
  parameter int RD_RECOVER_CYC = 1,
  parameter int FAIR           = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   txe,
  input  logic                   rxf,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   wrreq,
  input  logic [7:0]             data_wr,
  input  logic                   rdreq,
  output logic [7:0]             data_rd,
  input  logic [7:0]             adbus_in,
  output logic [7:0]             adbus_out,
  output logic                   adbus_tri,
  output logic                   ftdi_wr,
  output logic                   ftdi_rd,
  output logic                   rdq_full,
  output logic                   rdq_empty,
  output logic                   wrq_full,
  output logic                   wrq_empty,
  output logic [$clog2(DEPTH):0] rdq_used,
  output logic [$clog2(DEPTH):0] wrq_used,
  output logic                   busy
);
  localparam int MAX_WR = (WR_SETUP_CYC > WR_PULSE_CYC) ? WR_SETUP_CYC : WR_PULSE_CYC;
  localparam int MAX_RD = (RD_PULSE_CYC > RD_RECOVER_CYC) ? RD_PULSE_CYC : RD_RECOVER_CYC;
  localparam int MAXC   = (MAX_WR > MAX_RD) ? MAX_WR : MAX_RD;
  localparam int CNT_W  = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WR_SETUP   = 3'd1;
  localparam logic [2:0] WR_PULSE   = 3'd2;
  localparam logic [2:0] RD_PULSE   = 3'd3;
  localparam logic [2:0] RD_RECOVER = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             tok_rd;
  logic             txe_s;
  logic             rxf_s;
  logic             rd_elig;
  logic             wr_elig;
  logic             start_rd;
  logic             start_wr;
  logic             rx_push;
  logic [7:0]       tx_head;

`ifdef FTDI_SYNC_EN
  logic [1:0] txe_sync;
  logic [1:0] rxf_sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txe_sync <= 2'b11;
      rxf_sync <= 2'b11;
    end else begin
      txe_sync <= {txe_sync[0], txe};
      rxf_sync <= {rxf_sync[0], rxf};
    end
  end

  assign txe_s = txe_sync[1];
  assign rxf_s = rxf_sync[1];
`else
  assign txe_s = txe;
  assign rxf_s = rxf;
`endif

  // Eligibility is only looked at in IDLE, so pad changes during a
  // transaction never cut its timing short.
  assign rd_elig  = (state == IDLE) && !rxf_s && rd_en && !rdq_full;
  assign wr_elig  = (state == IDLE) && !txe_s && wr_en && !wrq_empty;
  assign start_rd = rd_elig && (!wr_elig || (FAIR == 0) || tok_rd);
  assign start_wr = wr_elig && !start_rd;
  // adbus_in is captured on the last cycle RD# is low.
  assign rx_push  = (state == RD_PULSE) && (cnt == '0);
  assign busy     = (state != IDLE);

  ftdi_fifo_bridge_queue #(.DEPTH(DEPTH)) u_rdq (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (rx_push),
    .din   (adbus_in),
    .pop   (rdreq),
    .dout  (data_rd),
    .full  (rdq_full),
    .empty (rdq_empty),
    .used  (rdq_used)
  );

  ftdi_fifo_bridge_queue #(.DEPTH(DEPTH)) u_wrq (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (wrreq),
    .din   (data_wr),
    .pop   (start_wr),
    .dout  (tx_head),
    .full  (wrq_full),
    .empty (wrq_empty),
    .used  (wrq_used)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tok_rd    <= 1'b1;
      adbus_out <= 8'h00;
      adbus_tri <= 1'b0;
      ftdi_wr   <= 1'b1;
      ftdi_rd   <= 1'b1;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      adbus_tri <= 1'b0;
      ftdi_wr   <= 1'b1;
      ftdi_rd   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_rd) begin
            state   <= RD_PULSE;
            cnt     <= CNT_W'(RD_PULSE_CYC - 1);
            ftdi_rd <= 1'b0;
            tok_rd  <= 1'b0;
          end else if (start_wr) begin
            state     <= WR_SETUP;
            cnt       <= CNT_W'(WR_SETUP_CYC - 1);
            adbus_out <= tx_head;
            adbus_tri <= 1'b1;
            tok_rd    <= 1'b1;
          end
        end
        WR_SETUP: begin
          if (cnt == '0) begin
            state   <= WR_PULSE;
            cnt     <= CNT_W'(WR_PULSE_CYC - 1);
            ftdi_wr <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            state     <= IDLE;
            ftdi_wr   <= 1'b1;
            adbus_tri <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_PULSE: begin
          if (cnt == '0) begin
            state   <= RD_RECOVER;
            cnt     <= CNT_W'(RD_RECOVER_CYC - 1);
            ftdi_rd <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RECOVER: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state     <= IDLE;
          adbus_tri <= 1'b0;
          ftdi_wr   <= 1'b1;
          ftdi_rd   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
module tb_ftdi_fifo_bridge;
  localparam int DEPTH = 16;
  localparam int UW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          txe = 1'b1;
  logic          rxf = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          wrreq = 1'b0;
  logic [7:0]    data_wr = 8'h00;
  logic          rdreq = 1'b0;
  logic [7:0]    data_rd;
  logic [7:0]    adbus_in = 8'h00;
  logic [7:0]    adbus_out;
  logic          adbus_tri;
  logic          ftdi_wr;
  logic          ftdi_rd;
  logic          rdq_full;
  logic          rdq_empty;
  logic          wrq_full;
  logic          wrq_empty;
  logic [UW-1:0] rdq_used;
  logic [UW-1:0] wrq_used;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int overlap_cnt = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] rx_src[$];
  logic [7:0] wr_obs[$];
  logic       txn_obs[$];
  logic       prev_wr = 1'b1;
  logic       prev_rd = 1'b1;

  always #5 clock = ~clock;

  ftdi_fifo_bridge #(.DEPTH(DEPTH), .FAIR(1)) dut (
    .clock(clock), .reset(reset), .clear(clear), .txe(txe), .rxf(rxf),
    .wr_en(wr_en), .rd_en(rd_en), .wrreq(wrreq), .data_wr(data_wr),
    .rdreq(rdreq), .data_rd(data_rd), .adbus_in(adbus_in),
    .adbus_out(adbus_out), .adbus_tri(adbus_tri), .ftdi_wr(ftdi_wr),
    .ftdi_rd(ftdi_rd), .rdq_full(rdq_full), .rdq_empty(rdq_empty),
    .wrq_full(wrq_full), .wrq_empty(wrq_empty), .rdq_used(rdq_used),
    .wrq_used(wrq_used), .busy(busy)
  );

  // FTDI-side model: records every WR# and RD# falling edge, serves read
  // bytes from rx_src and pushes what the DUT should capture onto rx_exp.
  always @(negedge clock) begin
    if (reset) begin
      prev_wr = 1'b1;
      prev_rd = 1'b1;
    end else begin
      if (prev_wr && !ftdi_wr) begin
        wr_obs.push_back(adbus_out);
        txn_obs.push_back(1'b0);
      end
      if (prev_rd && !ftdi_rd) begin
        txn_obs.push_back(1'b1);
        if (rx_src.size() > 0) adbus_in = rx_src.pop_front();
        rx_exp.push_back(adbus_in);
      end
      if (adbus_tri && !ftdi_rd) overlap_cnt++;
      prev_wr = ftdi_wr;
      prev_rd = ftdi_rd;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flush_model();
    tx_exp.delete();
    rx_exp.delete();
    rx_src.delete();
    wr_obs.delete();
    txn_obs.delete();
  endtask

  task automatic do_reset();
    txe = 1'b1; rxf = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wrreq = 1'b0; rdreq = 1'b0; clear = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    flush_model();
  endtask

  task automatic test_reset();
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        reset = 1'b0;
        tick();
      end
      checks++;
      if ({adbus_tri, ftdi_wr, ftdi_rd, busy} !== 4'b0110) begin
        failures++;
        $display("FAIL reset_strobes phase=%0d got tri/wr/rd/busy=%b want 0110", k, {adbus_tri, ftdi_wr, ftdi_rd, busy});
      end
      checks++;
      if (adbus_out !== 8'h00) begin
        failures++;
        $display("FAIL reset_adbus_out got %h want 00", adbus_out);
      end
      checks++;
      if ({rdq_empty, rdq_full, wrq_empty, wrq_full} !== 4'b1010 || rdq_used !== '0 || wrq_used !== '0) begin
        failures++;
        $display("FAIL reset_queues got flags=%b rdu=%0d wru=%0d want 1010 0 0", {rdq_empty, rdq_full, wrq_empty, wrq_full}, rdq_used, wrq_used);
      end
    end
    flush_model();
  endtask

  task automatic test_write();
    logic [4:0] e_tri;
    logic [4:0] e_wr;
    logic [7:0] b;
    e_tri = 5'b01110;
    e_wr  = 5'b10011;
    txe = 1'b0; wr_en = 1'b1;
    data_wr = 8'hA5; wrreq = 1'b1; tx_exp.push_back(8'hA5);
    tick();
    wrreq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (adbus_tri !== e_tri[i] || ftdi_wr !== e_wr[i]) begin
        failures++;
        $display("FAIL write_timing cyc=%0d got tri=%b wr=%b want tri=%b wr=%b", i, adbus_tri, ftdi_wr, e_tri[i], e_wr[i]);
      end
      if (i == 0) begin
        checks++;
        if (wrq_used !== UW'(1)) begin
          failures++;
          $display("FAIL write_used got %0d want 1", wrq_used);
        end
      end
      if (i == 2) begin
        checks++;
        if (adbus_out !== 8'hA5 || wrq_empty !== 1'b1) begin
          failures++;
          $display("FAIL write_data got out=%h empty=%b want A5 1", adbus_out, wrq_empty);
        end
      end
      tick();
    end
    txe = 1'b1; wr_en = 1'b0;
    checks++;
    if (wr_obs.size() != 1 || tx_exp.size() != 1) begin
      failures++;
      $display("FAIL write_count got %0d want 1", wr_obs.size());
    end else begin
      b = tx_exp.pop_front();
      checks++;
      if (wr_obs[0] !== b) begin
        failures++;
        $display("FAIL write_byte got %h want %h", wr_obs[0], b);
      end
    end
    flush_model();
  endtask

  task automatic test_read();
    logic [2:0] e_rd;
    logic [7:0] b;
    e_rd = 3'b100;
    rx_src.push_back(8'h3C);
    rd_en = 1'b1; rxf = 1'b0;
    tick();
    rxf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ftdi_rd !== e_rd[i] || adbus_tri !== 1'b0) begin
        failures++;
        $display("FAIL read_timing cyc=%0d got rd=%b tri=%b want rd=%b tri=0", i, ftdi_rd, adbus_tri, e_rd[i]);
      end
      if (i < 2) tick();
    end
    checks++;
    if (rdq_used !== UW'(1) || rx_exp.size() != 1) begin
      failures++;
      $display("FAIL read_used got %0d (model %0d) want 1", rdq_used, rx_exp.size());
    end else begin
      b = rx_exp.pop_front();
      checks++;
      if (data_rd !== b) begin
        failures++;
        $display("FAIL read_data got %h want %h", data_rd, b);
      end
    end
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    checks++;
    if (rdq_empty !== 1'b1 || rdq_used !== '0) begin
      failures++;
      $display("FAIL read_pop got empty=%b used=%0d want 1 0", rdq_empty, rdq_used);
    end
    rd_en = 1'b0;
    tick();
    flush_model();
  endtask

  task automatic test_fairness();
    logic [3:0] e_seq;
    logic [7:0] b;
    int n;
    do_reset();
    e_seq = 4'b0101;  // bit0 first: R, W, R, W
    for (int i = 0; i < 2; i++) begin
      data_wr = 8'(8'h11 * (i + 1)); wrreq = 1'b1; tx_exp.push_back(data_wr);
      tick();
    end
    wrreq = 1'b0;
    rx_src.push_back(8'h81);
    rx_src.push_back(8'h82);
    txe = 1'b0; rxf = 1'b0; wr_en = 1'b1; rd_en = 1'b1;
    n = 0;
    while (txn_obs.size() < 4 && n < 80) begin
      tick();
      n++;
    end
    rxf = 1'b1; txe = 1'b1;
    checks++;
    if (txn_obs.size() < 4) begin
      failures++;
      $display("FAIL fair_timeout got %0d transactions want 4", txn_obs.size());
    end
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 4 && i < txn_obs.size(); i++) begin
      checks++;
      if (txn_obs[i] !== e_seq[i]) begin
        failures++;
        $display("FAIL fair_order idx=%0d got read=%b want read=%b", i, txn_obs[i], e_seq[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      b = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'hxx;
      if (i >= wr_obs.size() || wr_obs[i] !== b) begin
        failures++;
        $display("FAIL fair_wbyte idx=%0d got %h want %h", i, (i < wr_obs.size()) ? wr_obs[i] : 8'hxx, b);
      end
    end
    for (int i = 0; i < 2; i++) begin
      b = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'hxx;
      checks++;
      if (data_rd !== b || rdq_empty !== 1'b0) begin
        failures++;
        $display("FAIL fair_rbyte idx=%0d got %h empty=%b want %h", i, data_rd, rdq_empty, b);
      end
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
    end
    flush_model();
  endtask

  task automatic test_tx_full();
    int n;
    txe = 1'b1; wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      data_wr = 8'(i * 13 + 5); wrreq = 1'b1; tx_exp.push_back(data_wr);
      tick();
    end
    data_wr = 8'hFF;
    tick();
    wrreq = 1'b0;
    checks++;
    if (wrq_full !== 1'b1 || wrq_used !== UW'(DEPTH)) begin
      failures++;
      $display("FAIL txfull_flags got full=%b used=%0d want 1 %0d", wrq_full, wrq_used, DEPTH);
    end
    txe = 1'b0; wr_en = 1'b1;
    n = 0;
    while (!(wrq_empty && !busy) && n < 200) begin
      tick();
      n++;
    end
    txe = 1'b1; wr_en = 1'b0;
    checks++;
    if (wr_obs.size() != DEPTH) begin
      failures++;
      $display("FAIL txfull_count got %0d want %0d", wr_obs.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < wr_obs.size(); i++) begin
      checks++;
      if (wr_obs[i] !== tx_exp[i]) begin
        failures++;
        $display("FAIL txfull_byte idx=%0d got %h want %h", i, wr_obs[i], tx_exp[i]);
      end
    end
    flush_model();
  endtask

  task automatic test_rx_full();
    int n;
    int n0;
    int got;
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) rx_src.push_back(8'(8'h40 + i));
    rd_en = 1'b1; rxf = 1'b0;
    n = 0;
    while (!rdq_full && n < 200) begin
      tick();
      n++;
    end
    n0 = txn_obs.size();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (txn_obs.size() != n0 || ftdi_rd !== 1'b1 || rdq_used !== UW'(DEPTH)) begin
      failures++;
      $display("FAIL rxfull_block got reads=%0d rd=%b used=%0d want %0d 1 %0d", txn_obs.size(), ftdi_rd, rdq_used, n0, DEPTH);
    end
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    got = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (!ftdi_rd) begin
        got = 1;
        break;
      end
    end
    rxf = 1'b1;
    checks++;
    if (got != 1) begin
      failures++;
      $display("FAIL rxfull_restart got rd=%b want 0 within 2 cycles", ftdi_rd);
    end
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    rd_en = 1'b0;
    // The first byte was popped by the single rdreq above.
    if (rx_exp.size() > 0) void'(rx_exp.pop_front());
    n = 0;
    while (!rdq_empty && n < DEPTH + 4) begin
      b = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'hxx;
      checks++;
      if (data_rd !== b) begin
        failures++;
        $display("FAIL rxfull_byte idx=%0d got %h want %h", n, data_rd, b);
      end
      rdreq = 1'b1;
      tick();
      rdreq = 1'b0;
      n++;
    end
    checks++;
    if (n != DEPTH || rx_exp.size() != 0) begin
      failures++;
      $display("FAIL rxfull_drain got %0d bytes (left %0d) want %0d", n, rx_exp.size(), DEPTH);
    end
    flush_model();
  endtask

  task automatic test_clear();
    int n;
    txe = 1'b1; wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_wr = 8'(8'hC0 + i); wrreq = 1'b1; tx_exp.push_back(data_wr);
      tick();
    end
    wrreq = 1'b0;
    rx_src.push_back(8'h77);
    rd_en = 1'b1; rxf = 1'b0;
    tick();
    rxf = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    rd_en = 1'b0;
    txe = 1'b0; wr_en = 1'b1;
    n = 0;
    while (ftdi_wr && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ftdi_wr !== 1'b0 || rdq_used !== UW'(1)) begin
      failures++;
      $display("FAIL clear_setup got wr=%b rdu=%0d want 0 1", ftdi_wr, rdq_used);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({ftdi_wr, adbus_tri, busy, wrq_empty, rdq_empty} !== 5'b10011 || wrq_used !== '0 || rdq_used !== '0) begin
      failures++;
      $display("FAIL clear_state got wr/tri/busy/wqe/rqe=%b wru=%0d rdu=%0d want 10011 0 0", {ftdi_wr, adbus_tri, busy, wrq_empty, rdq_empty}, wrq_used, rdq_used);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (wr_obs.size() != 1 || wr_obs[0] !== tx_exp[0] || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_after got writes=%0d busy=%b want 1 0", wr_obs.size(), busy);
    end
    txe = 1'b1; wr_en = 1'b0;
    flush_model();
  endtask

  task automatic test_async_reset();
    int n;
    data_wr = 8'h5A; wrreq = 1'b1;
    tick();
    wrreq = 1'b0;
    txe = 1'b0; wr_en = 1'b1;
    n = 0;
    while (ftdi_wr && n < 20) begin
      tick();
      n++;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ftdi_wr, ftdi_rd, adbus_tri, busy} !== 4'b1100 || adbus_out !== 8'h00 || wrq_empty !== 1'b1) begin
      failures++;
      $display("FAIL async_reset got wr/rd/tri/busy=%b out=%h wqe=%b want 1100 00 1", {ftdi_wr, ftdi_rd, adbus_tri, busy}, adbus_out, wrq_empty);
    end
    txe = 1'b1; wr_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    flush_model();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fairness();
    test_tx_full();
    test_rx_full();
    test_clear();
    test_async_reset();
    checks++;
    if (overlap_cnt !== 0) begin
      failures++;
      $display("FAIL tri_rd_overlap got %0d cycles want 0", overlap_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
